// File: rtl/serial_frame_scheduler.sv
// Round-robin arbiter that shares one sendFrame transmitter among N requesters,
// with an idle gap between frames and a watchdog that aborts stalled frames.
module serial_frame_scheduler #(
    parameter int unsigned N       = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LOGSIZE = 1,
    parameter int unsigned GAP     = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   req_data,
    output logic [LOGSIZE-1:0]   req_index,
    output logic [N-1:0]         grant,
    output logic [N-1:0]         done,
    output logic                 timeout_err,
    output logic                 busy,
    output logic                 frame_start,
    input  logic [LOGSIZE-1:0]   frame_index,
    output logic [WIDTH-1:0]     frame_data,
    input  logic                 frame_ready_at_next
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   last_grant_n;
    logic [CW-1:0]   wd_cnt;
    logic [CW-1:0]   wd_cnt_n;
    logic [CW-1:0]   gap_cnt;
    logic [CW-1:0]   gap_cnt_n;
    logic [N-1:0]    grant_n;
    logic [N-1:0]    done_n;
    logic            timeout_n;
    logic            start_n;
    logic            busy_n;
    logic            finish;

    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    int unsigned     cand;

    // Rotating priority search starting just after the previous owner.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = 32'(last_grant) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!pick_found && req[cand[IW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    // Word steering follows the transmitter's index with no register stage.
    assign req_index = frame_index;

    always_comb begin
        frame_data = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (grant[k]) begin
                frame_data = frame_data | req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        done_n       = '0;
        timeout_n    = 1'b0;
        start_n      = 1'b0;
        last_grant_n = last_grant;
        wd_cnt_n     = wd_cnt;
        gap_cnt_n    = gap_cnt;
        finish       = 1'b0;

        case (state)
            ST_IDLE: begin
                // The ready guard also covers a frame still draining after reset.
                if (pick_found && frame_ready_at_next) begin
                    state_n      = ST_START;
                    grant_n      = N'(1) << pick_idx;
                    last_grant_n = pick_idx;
                    start_n      = 1'b1;
                end
            end
            ST_START: begin
                state_n  = ST_SEND;
                wd_cnt_n = '0;
            end
            ST_SEND: begin
                wd_cnt_n = wd_cnt + CW'(1);
                // readyAtNext may still reflect the previous frame on the first SEND cycle.
                if ((wd_cnt != '0) && frame_ready_at_next) begin
                    finish = 1'b1;
                end else if (wd_cnt == WD_LAST) begin
                    finish    = 1'b1;
                    timeout_n = 1'b1;
                end
                if (finish) begin
                    done_n    = grant;
                    grant_n   = '0;
                    gap_cnt_n = '0;
                    state_n   = (GAP == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_n = gap_cnt + CW'(1);
                if (gap_cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant       <= '0;
            done        <= '0;
            timeout_err <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            last_grant  <= IW'(N - 1);
            wd_cnt      <= '0;
            gap_cnt     <= '0;
        end else begin
            grant       <= grant_n;
            done        <= done_n;
            timeout_err <= timeout_n;
            frame_start <= start_n;
            busy        <= busy_n;
            last_grant  <= last_grant_n;
            wd_cnt      <= wd_cnt_n;
            gap_cnt     <= gap_cnt_n;
        end
    end

endmodule
